// File: rtl/instruction_fetch_controller.sv
// ============================================================================
// Module   : instruction_fetch_controller
// Purpose  : CPU-side issue engine. Fetches 59-bit instruction words from a
//            32-entry instruction memory, stamps the PC into field [36:32],
//            hands each word to the decoder with a start/busy/done handshake,
//            then adopts the decoder's next PC. A per-instruction watchdog
//            traps a stuck decoder, and completing HALT_PC stops execution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_controller #(
  parameter logic [4:0]  RESET_PC       = 5'd0,
  parameter logic [4:0]  HALT_PC        = 5'd31,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_rd_en,
  output logic [4:0]       imem_addr,
  input  logic [58:0]      imem_rdata,
  output logic             dec_start,
  output logic [58:0]      dec_instruction,
  input  logic             dec_busy,
  input  logic             dec_done,
  input  logic             dec_fetch_stage_enable,
  input  logic [4:0]       dec_next_pc,
  output logic [4:0]       pc,
  output logic             running,
  output logic             halted,
  output logic             timeout_err,
  output logic             poll_flag,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_UPDATE    = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [15:0]        r_watchdog;
  logic [15:0]        w_watchdog_inc;
  logic               w_wd_expired;
  logic               w_retire_halt;
  logic               w_enter_error;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_unused_pc_field;

  // The memory's own PC field is overwritten with the fetch PC, so it is never consumed.
  assign w_unused_pc_field = ^imem_rdata[36:32];

  assign imem_addr      = pc;
  assign w_watchdog_inc = r_watchdog + 16'd1;
  // The current ISSUE/WAIT_DONE cycle is the last one the watchdog allows.
  assign w_wd_expired   = (w_watchdog_inc == TIMEOUT_CYCLES);
  // Halt is decided on the PC of the instruction being retired, as stamped at LATCH.
  assign w_retire_halt  = (dec_instruction[36:32] == HALT_PC);
  assign w_count_inc    = instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_enter_error  = ((r_state == S_ISSUE) || (r_state == S_WAIT_DONE)) &&
                          (w_next_state == S_ERROR);

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the state-derived strobes.
  always_comb begin
    w_next_state = r_state;
    imem_rd_en   = 1'b0;
    running      = 1'b1;
    case (r_state)
      S_IDLE: begin
        running = 1'b0;
        if (run && !halted) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_rd_en   = 1'b1;
        w_next_state = S_LATCH;
      end
      S_LATCH: begin
        w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        // Start is only withdrawn once the decoder has acknowledged with busy.
        if (dec_busy) begin
          w_next_state = S_WAIT_DONE;
        end else if (w_wd_expired) begin
          w_next_state = S_ERROR;
        end
      end
      S_WAIT_DONE: begin
        // A done still high from the previous instruction while busy is ignored.
        if (dec_done && !dec_busy) begin
          w_next_state = S_UPDATE;
        end else if (w_wd_expired) begin
          w_next_state = S_ERROR;
        end
      end
      S_UPDATE: begin
        if (w_retire_halt) begin
          w_next_state = S_IDLE;
        end else if (run) begin
          w_next_state = S_FETCH;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ERROR: begin
        running      = 1'b0;
        w_next_state = S_ERROR;
      end
      default: begin
        running      = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: instruction latch, start handshake, watchdog, PC and status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc              <= RESET_PC;
      dec_start       <= 1'b0;
      dec_instruction <= 59'd0;
      r_watchdog      <= 16'd0;
      halted          <= 1'b0;
      timeout_err     <= 1'b0;
      poll_flag       <= 1'b0;
      instr_count     <= {CNT_W{1'b0}};
    end else begin
      poll_flag <= dec_fetch_stage_enable;
      case (r_state)
        S_LATCH: begin
          dec_instruction <= {imem_rdata[58:37], pc, imem_rdata[31:0]};
          r_watchdog      <= 16'd0;
          dec_start       <= 1'b1;
        end
        S_ISSUE: begin
          r_watchdog <= w_watchdog_inc;
          if (w_next_state != S_ISSUE) begin
            dec_start <= 1'b0;
          end
        end
        S_WAIT_DONE: begin
          r_watchdog <= w_watchdog_inc;
        end
        S_UPDATE: begin
          instr_count <= w_count_inc;
          if (w_retire_halt) begin
            halted <= 1'b1;
          end else begin
            pc <= dec_next_pc;
          end
        end
        default: begin
        end
      endcase
      if (w_enter_error) begin
        timeout_err <= 1'b1;
        dec_start   <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_controller.sv
// ============================================================================
// Module   : tb_instruction_fetch_controller
// Purpose  : Directed bench for instruction_fetch_controller: handshake,
//            stale-done rejection, PC wrap, halt, watchdog and async reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_controller;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_rd_en;
  logic [4:0]  imem_addr;
  logic [58:0] imem_rdata;
  logic        dec_start;
  logic [58:0] dec_instruction;
  logic        dec_busy;
  logic        dec_done;
  logic        dec_fetch_stage_enable;
  logic [4:0]  dec_next_pc;
  logic [4:0]  pc;
  logic        running;
  logic        halted;
  logic        timeout_err;
  logic        poll_flag;
  logic [15:0] instr_count;

  logic [58:0] mem [32];
  logic [58:0] exp_add;
  int checks;
  int errors;

  instruction_fetch_controller #(
    .RESET_PC      (5'd0),
    .HALT_PC       (5'd3),
    .TIMEOUT_CYCLES(16'd16),
    .CNT_W         (16)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .run                   (run),
    .imem_rd_en            (imem_rd_en),
    .imem_addr             (imem_addr),
    .imem_rdata            (imem_rdata),
    .dec_start             (dec_start),
    .dec_instruction       (dec_instruction),
    .dec_busy              (dec_busy),
    .dec_done              (dec_done),
    .dec_fetch_stage_enable(dec_fetch_stage_enable),
    .dec_next_pc           (dec_next_pc),
    .pc                    (pc),
    .running               (running),
    .halted                (halted),
    .timeout_err           (timeout_err),
    .poll_flag             (poll_flag),
    .instr_count           (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction with the shortest handshake, starting in FETCH.
  task automatic issue_instr(input logic [4:0] exp_pc, input logic [4:0] nxt);
    logic [58:0] word;
    word = mem[exp_pc];
    check("fetch_rd_en", 64'(imem_rd_en), 64'd1);
    check("fetch_addr", 64'(imem_addr), 64'(exp_pc));
    tick();                                  // LATCH
    tick();                                  // ISSUE
    check("issue_start", 64'(dec_start), 64'd1);
    check("issue_word", 64'(dec_instruction), 64'({word[58:37], exp_pc, word[31:0]}));
    dec_busy = 1'b1;
    tick();                                  // WAIT_DONE
    dec_busy    = 1'b0;
    dec_done    = 1'b1;
    dec_next_pc = nxt;
    tick();                                  // UPDATE
    dec_done = 1'b0;
    tick();                                  // FETCH or IDLE
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = {2'(i), 5'(i + 1), 5'(i), 5'(i + 2), 5'(i + 3), ~5'(i), 32'h1000_0000 + 32'(i)};
    end
    mem[0]  = {2'b00, 5'd1, 5'd1, 5'd2, 5'd3, 5'h1F, 32'd5};
    exp_add = {2'b00, 5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 32'd5};
    mem[1]  = {2'b01, 5'd2, 5'd4, 5'd5, 5'd6, 5'h0A, 32'hDEAD_BEEF};

    rst = 1'b0; run = 1'b0; dec_busy = 1'b0; dec_done = 1'b0;
    dec_fetch_stage_enable = 1'b0; dec_next_pc = 5'd0;
    #12;
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_start", 64'(dec_start), 64'd0);
    check("rst_instr", 64'(dec_instruction), 64'd0);
    check("rst_count", 64'(instr_count), 64'd0);
    check("rst_flags", 64'({running, halted, timeout_err, poll_flag, imem_rd_en}), 64'd0);
    rst = 1'b1;
    tick();
    check("idle_no_run", 64'({running, imem_rd_en}), 64'd0);
    dec_fetch_stage_enable = 1'b1;
    tick();
    check("poll_high", 64'(poll_flag), 64'd1);
    dec_fetch_stage_enable = 1'b0;
    run = 1'b1;
    tick();
    check("poll_low", 64'(poll_flag), 64'd0);
    check("fetch0_running", 64'(running), 64'd1);
    check("fetch0_rd_en", 64'(imem_rd_en), 64'd1);
    check("fetch0_addr", 64'(imem_addr), 64'd0);

    // First instruction: busy two cycles after start, done three cycles later.
    tick();                                  // LATCH
    check("latch_rd_en", 64'(imem_rd_en), 64'd0);
    tick();                                  // ISSUE cycle 1
    check("add_word", 64'(dec_instruction), 64'(exp_add));
    check("add_start_c1", 64'(dec_start), 64'd1);
    tick();                                  // ISSUE cycle 2, busy still low
    check("add_start_c2", 64'(dec_start), 64'd1);
    dec_busy = 1'b1;
    dec_next_pc = 5'd1;
    tick();                                  // WAIT_DONE
    check("add_start_drop", 64'(dec_start), 64'd0);
    tick();
    tick();
    check("add_wait_count", 64'(instr_count), 64'd0);
    dec_busy = 1'b0;
    dec_done = 1'b1;
    tick();                                  // UPDATE
    dec_done = 1'b0;
    tick();                                  // FETCH at 1
    check("add_pc", 64'(pc), 64'd1);
    check("add_count", 64'(instr_count), 64'd1);
    check("add_next_fetch", 64'({imem_rd_en, imem_addr}), 64'({1'b1, 5'd1}));

    // Stale done held high with busy must not retire the instruction.
    tick();                                  // LATCH
    tick();                                  // ISSUE
    check("stale_word", 64'(dec_instruction), 64'({mem[1][58:37], 5'd1, mem[1][31:0]}));
    dec_busy = 1'b1;
    dec_done = 1'b1;
    tick();                                  // WAIT_DONE
    check("stale_start_drop", 64'(dec_start), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stale_no_retire", 64'({imem_rd_en, instr_count}), 64'd1);
    end
    dec_busy = 1'b0;
    dec_next_pc = 5'd30;
    tick();                                  // UPDATE
    dec_done = 1'b0;
    tick();                                  // FETCH at 30
    check("stale_pc", 64'(pc), 64'd30);
    check("stale_count", 64'(instr_count), 64'd2);

    // PC sequence 30 -> 31 -> 0; neither is the halt PC.
    issue_instr(5'd30, 5'd31);
    check("wrap_pc31", 64'({halted, pc}), 64'({1'b0, 5'd31}));
    issue_instr(5'd31, 5'd0);
    check("wrap_pc0", 64'({halted, pc}), 64'({1'b0, 5'd0}));
    check("wrap_count", 64'(instr_count), 64'd4);
    issue_instr(5'd0, 5'd2);
    check("pre_rst_pc", 64'(pc), 64'd2);

    // Asynchronous reset in the middle of WAIT_DONE.
    tick();                                  // LATCH
    tick();                                  // ISSUE
    dec_busy = 1'b1;
    tick();                                  // WAIT_DONE
    #2;
    rst = 1'b0;
    dec_busy = 1'b0;
    #1;
    check("arst_pc", 64'(pc), 64'd0);
    check("arst_count", 64'(instr_count), 64'd0);
    check("arst_start", 64'(dec_start), 64'd0);
    check("arst_running", 64'(running), 64'd0);
    #2;
    rst = 1'b1;

    // Halt at PC 3 after the program 0 -> 1 -> 2 -> 3.
    tick();                                  // FETCH at 0
    issue_instr(5'd0, 5'd1);
    issue_instr(5'd1, 5'd2);
    issue_instr(5'd2, 5'd3);
    issue_instr(5'd3, 5'd7);
    check("halt_flag", 64'(halted), 64'd1);
    check("halt_count", 64'(instr_count), 64'd4);
    check("halt_pc", 64'(pc), 64'd3);
    check("halt_idle", 64'({running, imem_rd_en}), 64'd0);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    tick();
    check("halt_run_ignored", 64'({running, imem_rd_en, halted, pc}), 64'({1'b0, 1'b0, 1'b1, 5'd3}));

    // Watchdog: decoder never answers.
    #2;
    rst = 1'b0;
    #1;
    check("rst2_flags", 64'({halted, timeout_err}), 64'd0);
    #2;
    rst = 1'b1;
    tick();                                  // FETCH
    tick();                                  // LATCH
    tick();                                  // ISSUE cycle 1
    check("wd_start", 64'(dec_start), 64'd1);
    for (int i = 2; i <= 16; i++) begin
      tick();
      check("wd_holding", 64'({dec_start, timeout_err}), 64'b10);
    end
    tick();                                  // ERROR
    check("wd_start_drop", 64'(dec_start), 64'd0);
    check("wd_timeout_err", 64'(timeout_err), 64'd1);
    check("wd_running", 64'(running), 64'd0);
    dec_busy = 1'b1;
    dec_done = 1'b1;
    run = 1'b0;
    tick();
    run = 1'b1;
    dec_busy = 1'b0;
    tick();
    tick();
    check("err_terminal", 64'({timeout_err, running, imem_rd_en, dec_start}), 64'b1000);
    #2;
    rst = 1'b0;
    #1;
    check("err_rst_clear", 64'(timeout_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
